// File: rtl/proj_histogram_engine.sv
// Column (x) and row (y) projection histogram of a binary pixel stream with
// saturating bins, peak tracking, a self-clear sweep and a backpressured readout.
module proj_histogram_engine #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startHistogram,
    input  logic              pixWrite,
    input  logic [ADDR_W-1:0] xAddress,
    input  logic [ADDR_W-1:0] yAddress,
    input  logic              pixelData,
    input  logic              frameDone,
    input  logic              readHistogram,
    input  logic              outReady,
    output logic              outValid,
    output logic              outIsY,
    output logic [ADDR_W-1:0] outIndex,
    output logic [CNT_W-1:0]  outCount,
    output logic              outLast,
    output logic [ADDR_W-1:0] xPeakIndex,
    output logic [ADDR_W-1:0] yPeakIndex,
    output logic              histReady,
    output logic              busy,
    output logic              addrError
);

    localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int XI_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YI_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W:0]   X_LIM   = (ADDR_W+1)'(IMG_W);
    localparam logic [ADDR_W:0]   Y_LIM   = (ADDR_W+1)'(IMG_H);
    localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(MAXD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCUM  = 3'd2,
        S_DONE   = 3'd3,
        S_READ_X = 3'd4,
        S_READ_Y = 3'd5
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_xbin [IMG_W];
    logic [CNT_W-1:0]  r_ybin [IMG_H];
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] r_xpk_idx;
    logic [ADDR_W-1:0] r_ypk_idx;
    logic [CNT_W-1:0]  r_xpk_cnt;
    logic [CNT_W-1:0]  r_ypk_cnt;
    logic              r_addr_err;
    logic [ADDR_W-1:0] r_out_idx;
    logic [CNT_W-1:0]  r_out_cnt;
    logic              r_out_is_y;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    logic              w_pix_hit;
    logic              w_x_bad;
    logic              w_y_bad;
    logic              w_count;
    logic [XI_W-1:0]   w_xi;
    logic [YI_W-1:0]   w_yi;
    logic [CNT_W-1:0]  w_x_new;
    logic [CNT_W-1:0]  w_y_new;
    logic [ADDR_W-1:0] w_nidx;

    assign w_pix_hit = (r_state == S_ACCUM) && pixWrite;
    assign w_x_bad   = ({1'b0, xAddress} >= X_LIM);
    assign w_y_bad   = ({1'b0, yAddress} >= Y_LIM);
    assign w_count   = w_pix_hit && pixelData && !w_x_bad && !w_y_bad;
    assign w_xi      = xAddress[XI_W-1:0];
    assign w_yi      = yAddress[YI_W-1:0];
    assign w_x_new   = sat_inc(r_xbin[w_xi]);
    assign w_y_new   = sat_inc(r_ybin[w_yi]);
    assign w_nidx    = r_out_idx + ADDR_W'(1);

    // Bin storage: zeroed by the clear sweep, incremented during accumulation.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            if ({1'b0, r_clr_idx} < X_LIM) r_xbin[r_clr_idx[XI_W-1:0]] <= '0;
            if ({1'b0, r_clr_idx} < Y_LIM) r_ybin[r_clr_idx[YI_W-1:0]] <= '0;
        end else if (w_count) begin
            r_xbin[w_xi] <= w_x_new;
            r_ybin[w_yi] <= w_y_new;
        end
    end

    // Control FSM with peak tracking, error flag and readout beat registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_clr_idx  <= '0;
            r_xpk_idx  <= '0;
            r_ypk_idx  <= '0;
            r_xpk_cnt  <= '0;
            r_ypk_cnt  <= '0;
            r_addr_err <= 1'b0;
            r_out_idx  <= '0;
            r_out_cnt  <= '0;
            r_out_is_y <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (startHistogram) r_state <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_xpk_idx  <= '0;
                    r_ypk_idx  <= '0;
                    r_xpk_cnt  <= '0;
                    r_ypk_cnt  <= '0;
                    r_addr_err <= 1'b0;
                    if (r_clr_idx == C_LAST) begin
                        r_clr_idx <= '0;
                        r_state   <= S_ACCUM;
                    end else begin
                        r_clr_idx <= r_clr_idx + ADDR_W'(1);
                    end
                end
                S_ACCUM: begin
                    if (w_pix_hit && (w_x_bad || w_y_bad)) r_addr_err <= 1'b1;
                    // Strict compare: a bin that only ties the peak never displaces it.
                    if (w_count && (w_x_new > r_xpk_cnt)) begin
                        r_xpk_idx <= xAddress;
                        r_xpk_cnt <= w_x_new;
                    end
                    if (w_count && (w_y_new > r_ypk_cnt)) begin
                        r_ypk_idx <= yAddress;
                        r_ypk_cnt <= w_y_new;
                    end
                    if (frameDone) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (startHistogram) begin
                        r_state <= S_CLEAR;
                    end else if (readHistogram) begin
                        r_state    <= S_READ_X;
                        r_out_idx  <= '0;
                        r_out_cnt  <= r_xbin[0];
                        r_out_is_y <= 1'b0;
                    end
                end
                S_READ_X: begin
                    if (outReady) begin
                        if (r_out_idx == X_LAST) begin
                            r_state    <= S_READ_Y;
                            r_out_idx  <= '0;
                            r_out_cnt  <= r_ybin[0];
                            r_out_is_y <= 1'b1;
                        end else begin
                            r_out_idx <= w_nidx;
                            r_out_cnt <= r_xbin[w_nidx[XI_W-1:0]];
                        end
                    end
                end
                S_READ_Y: begin
                    if (outReady) begin
                        if (r_out_idx == Y_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_out_idx <= w_nidx;
                            r_out_cnt <= r_ybin[w_nidx[YI_W-1:0]];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign outValid   = (r_state == S_READ_X) || (r_state == S_READ_Y);
    assign outLast    = (r_state == S_READ_Y) && (r_out_idx == Y_LAST);
    assign outIsY     = r_out_is_y;
    assign outIndex   = r_out_idx;
    assign outCount   = r_out_cnt;
    assign xPeakIndex = r_xpk_idx;
    assign yPeakIndex = r_ypk_idx;
    assign addrError  = r_addr_err;
    assign histReady  = (r_state == S_DONE) || outValid;
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: tb/tb_proj_histogram_engine.sv
// Bench for proj_histogram_engine: directed table, corner sequences and random
// frames checked against a count-array reference model.
module tb_proj_histogram_engine;

    localparam int W = 10, H = 8, AW = 4, CW = 4, MAXD = 10, CMAX = 15;

    logic clk = 1'b0;
    logic reset, startHistogram, pixWrite, pixelData, frameDone, readHistogram, outReady;
    logic [AW-1:0] xAddress, yAddress;
    logic outValid, outIsY, outLast, histReady, busy, addrError;
    logic [AW-1:0] outIndex, xPeakIndex, yPeakIndex;
    logic [CW-1:0] outCount;

    proj_histogram_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .startHistogram(startHistogram), .pixWrite(pixWrite),
        .xAddress(xAddress), .yAddress(yAddress), .pixelData(pixelData),
        .frameDone(frameDone), .readHistogram(readHistogram), .outReady(outReady),
        .outValid(outValid), .outIsY(outIsY), .outIndex(outIndex), .outCount(outCount),
        .outLast(outLast), .xPeakIndex(xPeakIndex), .yPeakIndex(yPeakIndex),
        .histReady(histReady), .busy(busy), .addrError(addrError)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bin counts plus, per count value, the first bin to reach it.
    int mx [W];
    int my [H];
    int fx [CMAX+1];
    int fy [CMAX+1];
    bit merr;

    function automatic void model_clear();
        foreach (mx[i]) mx[i] = 0;
        foreach (my[i]) my[i] = 0;
        foreach (fx[i]) fx[i] = -1;
        foreach (fy[i]) fy[i] = -1;
        merr = 1'b0;
    endfunction

    function automatic void model_pixel(input bit wr, input int x, input int y, input bit d);
        if (!wr) return;
        if (x >= W || y >= H) begin
            merr = 1'b1;
            return;
        end
        if (!d) return;
        if (mx[x] < CMAX) begin
            mx[x]++;
            if (fx[mx[x]] < 0) fx[mx[x]] = x;
        end
        if (my[y] < CMAX) begin
            my[y]++;
            if (fy[my[y]] < 0) fy[my[y]] = y;
        end
    endfunction

    // Peak = the bin that first reached the highest count present.
    function automatic int xpeak();
        int m = 0;
        foreach (mx[i]) if (mx[i] > m) m = mx[i];
        return (m == 0) ? 0 : fx[m];
    endfunction

    function automatic int ypeak();
        int m = 0;
        foreach (my[i]) if (my[i] > m) m = my[i];
        return (m == 0) ? 0 : fy[m];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_frame();
        startHistogram = 1'b1;
        tick();
        startHistogram = 1'b0;
        model_clear();
        check("start_busy", {busy, histReady}, 32'h2);
        repeat (MAXD) tick();
        check("clear_err", addrError, merr);
    endtask

    task automatic pixel(input bit wr, input int x, input int y, input bit d, input bit fd);
        pixWrite  = wr;
        xAddress  = x[AW-1:0];
        yAddress  = y[AW-1:0];
        pixelData = d;
        frameDone = fd;
        tick();
        pixWrite  = 1'b0;
        frameDone = 1'b0;
        model_pixel(wr, x, y, d);
        check("xpeak", xPeakIndex, xpeak());
        check("ypeak", yPeakIndex, ypeak());
        check("addr_err", addrError, merr);
    endtask

    task automatic end_frame();
        frameDone = 1'b1;
        tick();
        frameDone = 1'b0;
        check("done_flags", {histReady, busy}, 32'h2);
    endtask

    // mode 0: always ready, 1: ready toggles each cycle, 2: random ready
    task automatic readout(input int mode);
        int beats = 0;
        int cyc = 0;
        logic rdy, ey, el;
        logic [AW-1:0] ei;
        logic [CW-1:0] ec;
        readHistogram = 1'b1;
        tick();
        readHistogram = 1'b0;
        check("first_valid", outValid, 1'b1);
        while (beats < W + H && cyc < 500) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom % 2);
            endcase
            outReady = rdy;
            ey = (beats >= W);
            ei = ey ? AW'(beats - W) : AW'(beats);
            ec = ey ? CW'(my[beats - W]) : CW'(mx[beats]);
            el = (beats == W + H - 1);
            check("beat", {outValid, outIsY, outIndex, outCount, outLast},
                  {1'b1, ey, ei, ec, el});
            if (rdy) beats++;
            tick();
            cyc++;
        end
        outReady = 1'b0;
        check("read_end", {outValid, histReady, busy}, 32'h2);
    endtask

    typedef struct {
        int x; int y; logic d;
        logic [AW-1:0] xp; logic [AW-1:0] yp; logic err;
    } vec_t;

    initial begin
        vec_t tv [7];
        tv[0] = '{x: 2,  y: 0, d: 1'b1, xp: 4'd2, yp: 4'd0, err: 1'b0};
        tv[1] = '{x: 2,  y: 1, d: 1'b1, xp: 4'd2, yp: 4'd0, err: 1'b0};
        tv[2] = '{x: 9,  y: 2, d: 1'b1, xp: 4'd2, yp: 4'd0, err: 1'b0};
        tv[3] = '{x: 9,  y: 3, d: 1'b1, xp: 4'd2, yp: 4'd0, err: 1'b0};
        tv[4] = '{x: 12, y: 3, d: 1'b1, xp: 4'd2, yp: 4'd0, err: 1'b1};
        tv[5] = '{x: 5,  y: 3, d: 1'b0, xp: 4'd2, yp: 4'd0, err: 1'b1};
        tv[6] = '{x: 9,  y: 3, d: 1'b1, xp: 4'd9, yp: 4'd3, err: 1'b1};

        reset = 1'b1; startHistogram = 1'b0; pixWrite = 1'b0; pixelData = 1'b0;
        frameDone = 1'b0; readHistogram = 1'b0; outReady = 1'b0;
        xAddress = '0; yAddress = '0;
        model_clear();
        repeat (3) tick();
        reset = 1'b0;
        check("reset_outs", {outValid, outIsY, outIndex, outCount, outLast, xPeakIndex,
                             yPeakIndex, histReady, busy, addrError}, 32'h0);

        readHistogram = 1'b1;
        tick();
        readHistogram = 1'b0;
        check("read_in_idle", {outValid, busy}, 32'h0);

        // Single pixel frame, read twice with different backpressure
        start_frame();
        pixel(1'b1, 3, 5, 1'b1, 1'b0);
        end_frame();
        check("single_peaks", {xPeakIndex, yPeakIndex}, {4'd3, 4'd5});
        readout(0);
        readout(1);

        // Saturation
        start_frame();
        repeat (20) pixel(1'b1, 7, 7, 1'b1, 1'b0);
        end_frame();
        readout(2);

        // Clear sweep length: pixels during CLEAR are dropped, the first after is counted
        startHistogram = 1'b1;
        tick();
        startHistogram = 1'b0;
        model_clear();
        repeat (MAXD) begin
            pixWrite = 1'b1; xAddress = 4'd0; yAddress = 4'd0; pixelData = 1'b1;
            tick();
        end
        pixel(1'b1, 1, 1, 1'b1, 1'b0);
        end_frame();
        readout(0);

        // Tie / address-error table; readHistogram during ACCUM must be ignored
        start_frame();
        foreach (tv[i]) begin
            pixel(1'b1, tv[i].x, tv[i].y, tv[i].d, 1'b0);
            check("tbl_row", {xPeakIndex, yPeakIndex, addrError}, {tv[i].xp, tv[i].yp, tv[i].err});
        end
        readHistogram = 1'b1;
        pixel(1'b0, 0, 0, 1'b0, 1'b0);
        readHistogram = 1'b0;
        check("read_in_accum", outValid, 1'b0);
        end_frame();
        check("err_sticky", addrError, 1'b1);
        readout(1);

        // Random frames against the model
        for (int f = 0; f < 3; f++) begin
            start_frame();
            for (int i = 0; i < 40; i++) begin
                int r, x, y;
                bit wr, d, fd;
                r  = int'($urandom % 10);
                wr = ($urandom % 4 != 0);
                x  = int'($urandom % W);
                y  = int'($urandom % H);
                d  = ($urandom % 4 != 0);
                if (r == 0) begin x = W + int'($urandom % (16 - W)); d = 1'b1; end
                if (r == 1) begin y = H + int'($urandom % (16 - H)); d = 1'b1; end
                fd = (f == 0) && (i == 39);
                if (i == 10) startHistogram = 1'b1;
                if (i == 15) readHistogram = 1'b1;
                pixel(wr, x, y, d, fd);
                startHistogram = 1'b0;
                readHistogram = 1'b0;
                if (i == 15) check("rnd_read_ignored", outValid, 1'b0);
            end
            if (f == 0) check("same_cycle_done", {histReady, busy}, 32'h2);
            else end_frame();
            readout(2);
        end

        // Reset in the middle of READ_X
        readHistogram = 1'b1;
        tick();
        readHistogram = 1'b0;
        outReady = 1'b1;
        repeat (3) tick();
        check("pre_reset_beat", {outValid, outIsY, outIndex}, {1'b1, 1'b0, 4'd3});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        outReady = 1'b0;
        check("reset_midread", {outValid, busy, histReady}, 32'h0);
        readHistogram = 1'b1;
        tick();
        readHistogram = 1'b0;
        check("read_after_reset", outValid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
